// File: rtl/soc_glip_downscale.sv
// Wide-to-narrow serializer feeding the master side of a GLIP channel.
// One lane per cycle; the next word is loaded while the last lane is accepted.
module soc_glip_downscale #(
  parameter int OUT_WIDTH = 16,
  parameter int N         = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N*OUT_WIDTH-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = N * OUT_WIDTH;
  localparam logic [CW-1:0] LAST_LANE = CW'(N - 1);

  logic [IW-1:0] hold_p0;
  logic [CW-1:0] cnt_p0;
  logic          vld_p0;
  logic          is_last;
  logic          in_accept;
  logic          out_xfer;

  // Lanes beyond N-1 are unreachable; they decode to zero rather than X.
  function automatic logic [OUT_WIDTH-1:0] lane_sel(input logic [IW-1:0] w,
                                                     input logic [CW-1:0] idx);
    logic [OUT_WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == CW'(k)) begin
        r = w[(MSB_FIRST ? (N - 1 - k) : k) * OUT_WIDTH +: OUT_WIDTH];
      end
    end
    return r;
  endfunction

  assign is_last   = (cnt_p0 == LAST_LANE);
  assign in_ready  = ~vld_p0 | (out_ready & is_last);
  assign in_accept = in_valid & in_ready;
  assign out_xfer  = vld_p0 & out_ready;

  assign out_valid = vld_p0;
  assign busy      = vld_p0;
  assign out_last  = vld_p0 & is_last;
  assign out_data  = lane_sel(hold_p0, cnt_p0);

  // Stage p0: hold register, lane counter and occupancy flag
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      cnt_p0  <= '0;
      hold_p0 <= '0;
    end else if (out_xfer) begin
      if (!is_last) begin
        cnt_p0 <= cnt_p0 + CW'(1);
      end else begin
        cnt_p0 <= '0;
        vld_p0 <= in_accept;
        if (in_accept) begin
          hold_p0 <= in_data;
        end
      end
    end else if (!vld_p0 && in_accept) begin
      hold_p0 <= in_data;
      cnt_p0  <= '0;
      vld_p0  <= 1'b1;
    end
  end

endmodule
